// File: rtl/rv32i_regfile.sv
// RV32I integer register file: one write port, two combinational read ports, x0 hardwired to zero.
// Post-reset scrub zeroes x1..x31; optional third read port under `RF_DEBUG_PORT_EN.
//
// state   | meaning
// S_CLEAR | scrubbing array[r_ptr] <= 0, reads return 0, o_Ready low
// S_READY | normal operation, writeback writes accepted
module rv32i_regfile #(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      i_RegDst,
  input  logic [XLEN-1:0] i_RegWrData,
  input  logic            i_RegWrEn,
  input  logic [4:0]      i_Rs1Addr,
  input  logic [4:0]      i_Rs2Addr,
`ifdef RF_DEBUG_PORT_EN
  input  logic [4:0]      i_DbgAddr,
  output logic [XLEN-1:0] o_DbgData,
`endif
  output logic [XLEN-1:0] o_Rs1Data,
  output logic [XLEN-1:0] o_Rs2Data,
  output logic            o_Ready
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [4:0]      r_ptr;
  logic [4:0]      w_ptr_nxt;

  logic            w_we;
  logic [4:0]      w_wa;
  logic [XLEN-1:0] w_wd;

  // No reset on the array so it can map onto RAM; the scrub provides the zeroing.
  logic [XLEN-1:0] r_mem [1:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_CLEAR;
      r_ptr   <= 5'd1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_we        = 1'b0;
    w_wa        = i_RegDst;
    w_wd        = i_RegWrData;
    case (r_state)
      S_CLEAR: begin
        w_we = 1'b1;
        w_wa = r_ptr;
        w_wd = '0;
        if (r_ptr == 5'd31) begin
          w_state_nxt = S_READY;
        end else begin
          w_ptr_nxt = r_ptr + 5'd1;
        end
      end
      S_READY: begin
        w_we = i_RegWrEn && (i_RegDst != 5'd0);
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wa] <= w_wd;
    end
  end

  function automatic logic [XLEN-1:0] f_read(input logic [4:0] a);
    logic [XLEN-1:0] v;
    v = '0;
    if (r_state == S_READY && a != 5'd0) begin
      if (BYPASS && i_RegWrEn && (i_RegDst == a)) begin
        v = i_RegWrData;
      end else begin
        v = r_mem[a];
      end
    end
    return v;
  endfunction

  always_comb begin
    o_Rs1Data = f_read(i_Rs1Addr);
    o_Rs2Data = f_read(i_Rs2Addr);
  end

`ifdef RF_DEBUG_PORT_EN
  always_comb begin
    o_DbgData = f_read(i_DbgAddr);
  end
`endif

  assign o_Ready = (r_state == S_READY);

endmodule

// File: tb/tb_rv32i_regfile.sv
// Self-checking bench for rv32i_regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model, on BYPASS=1 and BYPASS=0 instances.
module tb_rv32i_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  dst, rs1, rs2;
  logic [31:0] wd;
  logic        wen;

  logic [31:0] b1_rs1, b1_rs2, b0_rs1, b0_rs2;
  logic        b1_rdy, b0_rdy;
`ifdef RF_DEBUG_PORT_EN
  logic [31:0] b1_dbg, b0_dbg;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [32];
  bit          m_ready;
  int          m_cnt;

  always #5 clk = ~clk;

  rv32i_regfile #(.XLEN(32), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .i_RegDst(dst), .i_RegWrData(wd), .i_RegWrEn(wen),
    .i_Rs1Addr(rs1), .i_Rs2Addr(rs2),
`ifdef RF_DEBUG_PORT_EN
    .i_DbgAddr(rs2), .o_DbgData(b1_dbg),
`endif
    .o_Rs1Data(b1_rs1), .o_Rs2Data(b1_rs2), .o_Ready(b1_rdy)
  );

  rv32i_regfile #(.XLEN(32), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .i_RegDst(dst), .i_RegWrData(wd), .i_RegWrEn(wen),
    .i_Rs1Addr(rs1), .i_Rs2Addr(rs2),
`ifdef RF_DEBUG_PORT_EN
    .i_DbgAddr(rs1), .o_DbgData(b0_dbg),
`endif
    .o_Rs1Data(b0_rs1), .o_Rs2Data(b0_rs2), .o_Ready(b0_rdy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (!m_ready || a == 5'd0) return 32'h0;
    if (byp && wen && dst == a) return wd;
    return m_mem[a];
  endfunction

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".rdy1"}, {31'h0, b1_rdy}, {31'h0, m_ready});
    chk({tag, ".rdy0"}, {31'h0, b0_rdy}, {31'h0, m_ready});
    chk({tag, ".b1rs1"}, b1_rs1, exp_rd(1'b1, rs1));
    chk({tag, ".b1rs2"}, b1_rs2, exp_rd(1'b1, rs2));
    chk({tag, ".b0rs1"}, b0_rs1, exp_rd(1'b0, rs1));
    chk({tag, ".b0rs2"}, b0_rs2, exp_rd(1'b0, rs2));
`ifdef RF_DEBUG_PORT_EN
    chk({tag, ".b1dbg"}, b1_dbg, exp_rd(1'b1, rs2));
    chk({tag, ".b0dbg"}, b0_dbg, exp_rd(1'b0, rs1));
`endif
  endtask

  // Advance one clock; model the commit at the edge, return at the following negedge.
  task automatic tick();
    @(posedge clk);
    if (m_ready) begin
      if (wen && dst != 5'd0) m_mem[dst] = wd;
    end else begin
      m_cnt++;
      if (m_cnt == 31) begin
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic [4:0] d, input logic [31:0] v,
                       input logic [4:0] a1, input logic [4:0] a2);
    wen = e; dst = d; wd = v; rs1 = a1; rs2 = a2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    m_ready = 1'b0;
    m_cnt   = 0;
    reset   = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
    repeat (3) @(negedge clk);
    check_all("reset");

    // Scrub with writes held asserted; they must be dropped.
    reset = 1'b1;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    for (int i = 1; i <= 31; i++) begin
      check_all($sformatf("scrub%0d", i));
      tick();
    end
    drive(1'b0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
    #1;
    chk("scrub.ready32", {31'h0, b1_rdy}, 32'h1);
    chk("scrub.x5", b1_rs1, 32'h0);
    chk("scrub.x5.b0", b0_rs2, 32'h0);

    drive(1'b1, 5'd1, 32'h12345678, 5'd0, 5'd2);
    check_all("wr_x1");
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
    #1;
    chk("basic.rs1", b1_rs1, 32'h12345678);
    chk("basic.rs2", b1_rs2, 32'h12345678);
    check_all("basic");

    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    chk("x0.same.b1", b1_rs1, 32'h0);
    chk("x0.same.b0", b0_rs1, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
    #1;
    chk("x0.next", b1_rs1, 32'h0);

    drive(1'b1, 5'd7, 32'hA5A5A5A5, 5'd1, 5'd7);
    #1;
    chk("byp1.same", b1_rs2, 32'hA5A5A5A5);
    chk("byp0.same", b0_rs2, 32'h0);
    tick();
    drive(1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
    #1;
    chk("byp0.next", b0_rs2, 32'hA5A5A5A5);
    chk("byp1.next", b1_rs1, 32'hA5A5A5A5);

    drive(1'b1, 5'd3, 32'h1, 5'd0, 5'd0); check_all("b2b.a"); tick();
    drive(1'b1, 5'd3, 32'h2, 5'd0, 5'd0); check_all("b2b.b"); tick();
    drive(1'b1, 5'd31, 32'h80000000, 5'd3, 5'd31); check_all("b2b.c"); tick();
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd31);
    #1;
    chk("b2b.x3", b1_rs1, 32'h2);
    chk("b2b.x31", b1_rs2, 32'h80000000);
    chk("b2b.x3.b0", b0_rs1, 32'h2);

    // Random traffic; small address window half the time to exercise bypass hits.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] d, a1, a2;
      if (n[0]) begin
        d  = 5'($urandom_range(0, 3));
        a1 = 5'($urandom_range(0, 3));
        a2 = 5'($urandom_range(0, 3));
      end else begin
        d  = 5'($urandom_range(0, 31));
        a1 = 5'($urandom_range(0, 31));
        a2 = 5'($urandom_range(0, 31));
      end
      drive(1'($urandom_range(0, 1)), d, $urandom, a1, a2);
      check_all($sformatf("rand%0d", n));
      tick();
    end

    // Reset mid-scrub, with a register written beforehand.
    drive(1'b1, 5'd9, 32'h55, 5'd9, 5'd9);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    #1;
    chk("pre.x9", b1_rs1, 32'h55);
    @(posedge clk);
    #2;
    reset = 1'b0;
    m_ready = 1'b0; m_cnt = 0;
    #1;
    chk("rst.ready.async", {31'h0, b1_rdy}, 32'h0);
    chk("rst.rd0", b1_rs1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      check_all($sformatf("part%0d", i));
      tick();
    end
    #2;
    reset = 1'b0;
    m_ready = 1'b0; m_cnt = 0;
    #1;
    chk("mid.ready.async", {31'h0, b1_rdy}, 32'h0);
    chk("mid.ready.async.b0", {31'h0, b0_rdy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      check_all($sformatf("rescrub%0d", i));
      tick();
    end
    #1;
    chk("rescrub.ready32", {31'h0, b1_rdy}, 32'h1);
    for (int r = 0; r < 32; r++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(r), 5'(31 - r));
      #1;
      chk($sformatf("zero.x%0d", r), b1_rs1, 32'h0);
      chk($sformatf("zero.b0.x%0d", 31 - r), b0_rs2, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
